// File: rtl/quad_pkg.sv
// Shared quadrature-decoding constants and the transition classifier.
package quad_pkg;

    // Debounced {A, B} levels, listed in clockwise Gray order.
    localparam logic [1:0] QS_00 = 2'b00;
    localparam logic [1:0] QS_01 = 2'b01;
    localparam logic [1:0] QS_11 = 2'b11;
    localparam logic [1:0] QS_10 = 2'b10;

    // Next state in the clockwise sequence 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] quad_cw_next(input logic [1:0] ab);
        logic [1:0] nxt;
        unique case (ab)
            QS_00:   nxt = QS_01;
            QS_01:   nxt = QS_11;
            QS_11:   nxt = QS_10;
            default: nxt = QS_00;
        endcase
        return nxt;
    endfunction

    // Classifies prev -> cur as {valid, up, illegal}.
    // valid: exactly one bit changed; up: that change follows clockwise order;
    // illegal: both bits changed at once.
    function automatic logic [2:0] quad_dir(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] diff;
        logic       valid;
        logic       up;
        logic       illegal;
        diff    = prev ^ cur;
        valid   = diff[1] ^ diff[0];
        illegal = diff[1] & diff[0];
        up      = valid && (cur == quad_cw_next(prev));
        return {valid, up, illegal};
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a stable-level debouncer for one encoder channel.
module sync_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic Clock,
    input  logic InReset,
    input  logic In,
    output logic Out
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic            sync1;
    logic            sync2;
    logic [CntW-1:0] stableCnt;
    logic [CntW-1:0] stableCntNext;
    logic            outNext;

    // Synchronise the asynchronous input into the Clock domain.
    always_ff @(posedge Clock or posedge InReset) begin
        if (InReset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= In;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES straight clocks.
    always_comb begin
        stableCntNext = '0;
        outNext       = Out;
        if (sync2 != Out) begin
            if (stableCnt == CntW'(DEBOUNCE_CYCLES - 1)) begin
                outNext = sync2;
            end else begin
                stableCntNext = stableCnt + 1'b1;
            end
        end
    end

    // Debounce counter and accepted level.
    always_ff @(posedge Clock or posedge InReset) begin
        if (InReset) begin
            stableCnt <= '0;
            Out       <= 1'b0;
        end else begin
            stableCnt <= stableCntNext;
            Out       <= outNext;
        end
    end

endmodule

// File: rtl/quad_paddle_decoder.sv
// Quadrature paddle decoder: conditions one encoder pair, decodes direction and keeps a
// saturating paddle position. Define QUAD_X4_EN to count every legal transition (x4);
// by default only arrivals at AB = 00 are counted (x1).
module quad_paddle_decoder
    import quad_pkg::*;
#(
    parameter int unsigned POS_WIDTH       = 4,
    parameter int unsigned POS_MAX         = 15,
    parameter int unsigned POS_INIT        = 7,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                 Clock,
    input  logic                 InReset,
    input  logic                 EncA,
    input  logic                 EncB,
    input  logic                 Recenter,
    output logic [POS_WIDTH-1:0] Position,
    output logic                 Step,
    output logic                 Dir,
    output logic                 Error
);

    // Debounced levels become trustworthy DEBOUNCE_CYCLES+2 clocks after reset.
    localparam int unsigned PrimeW = $clog2(DEBOUNCE_CYCLES + 3);

    logic                 encADeb;
    logic                 encBDeb;
    logic [1:0]           curAB;
    logic [1:0]           prevAB;
    logic                 primed;
    logic [PrimeW-1:0]    primeCnt;
    logic [2:0]           decodeBits;
    logic                 stepValid;
    logic                 errValid;
    logic [POS_WIDTH-1:0] posNext;

    sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uDebA (
        .Clock  (Clock),
        .InReset(InReset),
        .In     (EncA),
        .Out    (encADeb)
    );

    sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uDebB (
        .Clock  (Clock),
        .InReset(InReset),
        .In     (EncB),
        .Out    (encBDeb)
    );

    assign curAB = {encADeb, encBDeb};

    // Classify the transition and decide whether it is a counted step or an error.
    always_comb begin
        decodeBits = quad_dir(prevAB, curAB);
        stepValid  = 1'b0;
        errValid   = 1'b0;
        if (primed) begin
            errValid = decodeBits[0];
`ifdef QUAD_X4_EN
            stepValid = decodeBits[2];
`else
            stepValid = decodeBits[2] && (curAB == QS_00);
`endif
        end
    end

    // Next position: Recenter overrides any step; steps saturate at 0 and POS_MAX.
    always_comb begin
        posNext = Position;
        if (Recenter) begin
            posNext = POS_WIDTH'(POS_INIT);
        end else if (stepValid) begin
            if (decodeBits[1]) begin
                if (Position != POS_WIDTH'(POS_MAX)) posNext = Position + 1'b1;
            end else begin
                if (Position != '0) posNext = Position - 1'b1;
            end
        end
    end

    // Priming: wait out the conditioning latency, then latch the first settled AB.
    always_ff @(posedge Clock or posedge InReset) begin
        if (InReset) begin
            primeCnt <= '0;
            primed   <= 1'b0;
            prevAB   <= QS_00;
        end else if (primed) begin
            prevAB <= curAB;
        end else if (primeCnt == PrimeW'(DEBOUNCE_CYCLES + 2)) begin
            primed <= 1'b1;
            prevAB <= curAB;
        end else begin
            primeCnt <= primeCnt + 1'b1;
        end
    end

    // Registered outputs: event pulses, last direction and paddle position.
    always_ff @(posedge Clock or posedge InReset) begin
        if (InReset) begin
            Position <= POS_WIDTH'(POS_INIT);
            Step     <= 1'b0;
            Dir      <= 1'b0;
            Error    <= 1'b0;
        end else begin
            Position <= posNext;
            Step     <= stepValid;
            Error    <= errValid;
            if (stepValid) Dir <= decodeBits[1];
        end
    end

endmodule
